// File: rtl/sram_bank_rmw_if.sv
// Request/response bus of sram_bank_rmw: grant/valid handshake with byte-enabled writes.
interface sram_bank_rmw_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int BE_WIDTH   = (DATA_WIDTH + 7) / 8;

    logic                  req;
    logic                  gnt;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_bank_rmw.sv
// Tiled 16x256 1RW SRAM bank with byte-enable writes via internal read-modify-write.
// Define SRAM_BANK_OUT_REG_EN to add an output register stage (read latency 2).
module sram_asap7_16x256_1rw (
    input  logic        clk,
    input  logic        ce,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);
    logic [15:0] mem [256];

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

module sram_bank_rmw #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    sram_bank_rmw_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS);
    localparam int BE_WIDTH   = (DATA_WIDTH + 7) / 8;
    localparam int NUM_LANES  = (DATA_WIDTH + 15) / 16;
    localparam int NUM_BANKS  = NUM_WORDS / 256;
    localparam int PAD_W      = NUM_LANES * 16;
    localparam int PAD_BE     = NUM_LANES * 2;

    if (NUM_WORDS < 256 || (NUM_WORDS % 256) != 0) begin : g_bad_depth
        $error("sram_bank_rmw: NUM_WORDS must be a multiple of 256 and >= 256");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 512) begin : g_bad_width
        $error("sram_bank_rmw: DATA_WIDTH must be in 1..512");
    end

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_bank, bank_sel, rd_bank_q;
    logic                  req_in_range;
    logic [PAD_BE-1:0]     be_pad, rmw_be_q;
    logic [PAD_W-1:0]      wdata_pad, rmw_wdata_q, merged, cur_rd, mem_wdata;
    logic [7:0]            rmw_row_q, mem_row;
    logic [NUM_LANES-1:0]  lane_act, lane_part, rmw_act, lane_ce, lane_we;
    logic [NUM_BANKS-1:0]  bank_en;
    logic                  rd_accept, rmw_start, rd_pend_q;
    logic [15:0]           macro_rd [NUM_BANKS][NUM_LANES];
    logic [DATA_WIDTH-1:0] rdata_raw;

    assign req_bank     = ADDR_WIDTH'(bus.addr >> 8);
    assign req_in_range = req_bank < ADDR_WIDTH'(NUM_BANKS);
    assign wdata_pad    = PAD_W'(bus.wdata);

    // A padding byte copies its lane partner so a half-populated top lane is never partial.
    for (genvar i = 0; i < PAD_BE; i++) begin : g_be_pad
        if (i < BE_WIDTH) begin : g_real
            assign be_pad[i] = bus.be[i];
        end else begin : g_fill
            assign be_pad[i] = bus.be[i-1];
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_class
        assign lane_act[l]  = be_pad[2*l] | be_pad[2*l+1];
        assign lane_part[l] = be_pad[2*l] ^ be_pad[2*l+1];
        assign rmw_act[l]   = rmw_be_q[2*l] | rmw_be_q[2*l+1];
    end

    always_comb begin
        cur_rd = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank_q == ADDR_WIDTH'(b)) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    cur_rd[16*l +: 16] = macro_rd[b][l];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PAD_BE; i++) begin
            merged[8*i +: 8] = rmw_be_q[i] ? rmw_wdata_q[8*i +: 8] : cur_rd[8*i +: 8];
        end
    end

    assign bus.gnt = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        bank_sel  = req_bank;
        mem_row   = bus.addr[7:0];
        mem_wdata = wdata_pad;
        lane_ce   = '0;
        lane_we   = '0;
        rd_accept = 1'b0;
        rmw_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (!bus.we) begin
                        rd_accept = 1'b1;
                        lane_ce   = '1;
                    end else if (req_in_range) begin
                        if (|lane_part) begin
                            rmw_start = 1'b1;
                            lane_ce   = '1;
                            state_d   = RMW_WR;
                        end else begin
                            lane_ce = lane_act;
                            lane_we = lane_act;
                        end
                    end
                end
            end
            RMW_WR: begin
                bank_sel  = rd_bank_q;
                mem_row   = rmw_row_q;
                mem_wdata = merged;
                lane_ce   = rmw_act;
                lane_we   = rmw_act;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Macros are not reset, so a cycle under reset must not touch them.
        if (!rst_ni) begin
            lane_ce = '0;
            lane_we = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b] = (bank_sel == ADDR_WIDTH'(b));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rd_pend_q   <= 1'b0;
            rd_bank_q   <= '0;
            rmw_row_q   <= '0;
            rmw_wdata_q <= '0;
            rmw_be_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_accept;
            if (rd_accept || rmw_start) rd_bank_q <= req_bank;
            if (rmw_start) begin
                rmw_row_q   <= bus.addr[7:0];
                rmw_wdata_q <= wdata_pad;
                rmw_be_q    <= be_pad;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            sram_asap7_16x256_1rw u_macro (
                .clk   (clk_i),
                .ce    (bank_en[b] & lane_ce[l]),
                .we    (lane_we[l]),
                .addr  (mem_row),
                .wdata (mem_wdata[16*l +: 16]),
                .rdata (macro_rd[b][l])
            );
        end
    end

    assign rdata_raw = rd_pend_q ? cur_rd[DATA_WIDTH-1:0] : '0;

`ifdef SRAM_BANK_OUT_REG_EN
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_pend_q;
            rdata_q  <= rdata_raw;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
`else
    assign bus.rvalid = rd_pend_q;
    assign bus.rdata  = rdata_raw;
`endif
endmodule

// File: doc/sram_bank_rmw.md
Name: sram_bank_rmw

Overview:
- Parametrised single-port SRAM built from tiled sram_asap7_16x256_1rw hard macros (16 bit x 256 words, 1RW, 1-cycle read latency).
- Tiles in width: NUM_LANES = ceil(DATA_WIDTH/16) macros per bank.
- Tiles in depth: NUM_BANKS = NUM_WORDS/256 banks.
- Adds true byte-enable writes through an internal read-modify-write (RMW) sequence, a grant/valid handshake and an optional output register.
- Replaces the fixed 256-word, byte-enable-ignoring wrapper in cache and BTB memories.

Parameters:
DATA_WIDTH, 64, word width in bits, 1..512; padded internally to NUM_LANES*16.
NUM_WORDS, 1024, depth; must be a multiple of 256 and >= 256 (elaboration error otherwise).
ADDR_WIDTH, $clog2(NUM_WORDS), derived; not to be overridden.
BE_WIDTH, (DATA_WIDTH+7)/8, derived byte-enable width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_i  in  1  request; accepted when req_i && gnt_o
gnt_o  out  1  ready to accept a request this cycle
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  word address; [7:0] = macro row, upper bits = bank
wdata_i  in  DATA_WIDTH  write data
be_i  in  BE_WIDTH  byte enables (writes only)
rvalid_o  out  1  read data valid
rdata_o  out  DATA_WIDTH  read data; forced to 0 whenever rvalid_o = 0

Behaviour:
- One clock. Reset is synchronous and active-low, sampled on the rising clk_i edge.
- Reset values: FSM = IDLE, gnt_o = 1, rvalid_o = 0, rdata_o = 0. Macro contents are not reset.
- FSM states: IDLE and RMW_WR. gnt_o = 1 only in IDLE.
- Lane classification per accepted write, for each 16-bit lane L:
  - be pair {be[2L+1], be[2L]} = 00: lane untouched; ce and we deasserted for that lane.
  - be pair = 11: full lane write.
  - be pair = 01 or 10: partial lane.
  - Byte positions beyond BE_WIDTH count as enabled when their lane partner is enabled, so padding never forces RMW.
- Read (IDLE, accepted, we_i = 0):
  - All lanes of the selected bank get ce = 1, we = 0.
  - Next cycle: rvalid_o = 1 and rdata_o = that bank's lanes, truncated to DATA_WIDTH.
  - The bank index is registered at accept for the output mux.
  - Back-to-back reads give one result per cycle.
- Write with no partial lane: single cycle; stays in IDLE; no rvalid_o. be_i all zero is accepted as a no-op.
- Write with at least one partial lane:
  - Cycle 0 (accept): read all lanes of the bank; latch addr, wdata, be; go to RMW_WR.
  - Cycle 1 (RMW_WR, gnt_o = 0): merged = per-byte select(be ? wdata : macro rd_out). Write merged data to every lane with a nonzero be pair; lanes with 00 stay idle. Return to IDLE.
  - A new request is accepted in cycle 2 and sees the updated data.
- Out-of-range bank (bank index >= NUM_BANKS; only possible when NUM_BANKS is not a power of 2):
  - Writes are dropped.
  - Reads return rvalid_o = 1 with rdata_o = 0.
- At most one macro bank is enabled per cycle.
- Reset asserted in RMW_WR: the pending write is discarded and the stored word is unchanged. FSM = IDLE on the next cycle.
- Reset asserted while a read is outstanding: rvalid_o = 0 on the next cycle.
- req_i with gnt_o = 0: not accepted. The requester holds the request and it is accepted once gnt_o = 1. No queueing.

Optional Feature:
- Macro: SRAM_BANK_OUT_REG_EN.
- Defined:
  - rdata_o and rvalid_o pass through an additional register stage, so read latency = 2 cycles.
  - The register resets to rvalid_o = 0 and rdata_o = 0.
  - RMW timing is unchanged, because merge uses raw macro output.
  - Throughput stays 1 read per cycle.
- Undefined: read latency = 1 cycle, as described above.

Test Plan:
- Full write 0x1122334455667788 to addr 0x005 with be = 0xFF, then read 0x005 -> gnt_o stays 1 throughout; rvalid_o = 1 one cycle after the read is accepted (two with SRAM_BANK_OUT_REG_EN); rdata_o = 0x1122334455667788.
- Partial write of wdata = 0xAAAAAAAAAAAAAAAA to addr 0x005 with be = 0x01, then read 0x005 -> gnt_o = 0 for exactly 1 cycle; read returns 0x11223344556677AA.
- Lane-aligned partial write with be = 0x0C, wdata = 0x00000000BEEF0000, to addr 0x3FF (bank 3, row 255) -> no RMW (gnt_o stays 1); readback = prior word with bits [31:16] = 0xBEEF; banks 0..2 unchanged.
- Back-to-back reads of addr 0x000, 0x100, 0x200, 0x300, each pre-written with its own bank number -> four consecutive rvalid_o pulses carrying 0, 1, 2, 3.
- Assert reset in RMW_WR of a be = 0x01 write of 0xFF..FF to a word holding 0 -> after reset, a read of that word returns 0; gnt_o = 1 and rvalid_o = 0 during reset.
- DATA_WIDTH = 40, NUM_WORDS = 768: write 0x12_3456_789A with be = 0x10 -> no RMW; byte 4 updated; read of addr 0x300 (out of range) returns rvalid_o = 1 with rdata_o = 0.
